dp_memory: RTL and testbench
============================

Name: dp_memory

Overview:
- Parametrised dual-port word memory for the CPU: one read-only instruction port (i_*) and one read/write data port (d_*) sharing a single array.
- Adds per-byte write strobes, a req/gnt/rvalid handshake, configurable wait states and alignment/range error reporting.
- Sits between the core's fetch and load/store units and the on-chip RAM.

Parameters:
- DATA_W, 32, word width in bits; multiple of 8.
- DEPTH, 1024, number of words; power of two.
- WAIT_STATES, 0, extra cycles between request acceptance and array access; 0 to 15.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- i_req  in  1  instruction read request
- i_gnt  out  1  instruction port ready; request accepted when i_req && i_gnt
- i_addr  in  32  byte address
- i_rvalid  out  1  one-cycle response pulse
- i_rdata  out  DATA_W  read data
- i_err  out  1  error flag, valid with i_rvalid
- d_req  in  1  data request
- d_gnt  out  1  data port ready
- d_we  in  1  1 = write, 0 = read
- d_be  in  DATA_W/8  byte write strobes
- d_addr  in  32  byte address
- d_wdata  in  DATA_W  write data
- d_rvalid  out  1  response pulse (read data or write ack)
- d_rdata  out  DATA_W  read data
- d_err  out  1  error flag, valid with d_rvalid

Behaviour:
- Word index = addr[AW+1:2], where AW = log2(DEPTH).
- Each port runs an independent FSM: IDLE -> (WAIT_STATES > 0 ? WAIT : ACCESS) -> IDLE.
- gnt = 1 only in IDLE, and only when reset_n was high on the previous edge.
- Accept edge: the edge at which req && gnt. addr, we, be and wdata are latched there; the port's inputs are don't-care afterwards.
- Access edge = accept edge + WAIT_STATES cycles. The array read/write happens at the access edge. rvalid and rdata/err are registered there and are visible the cycle after it.
- Latency: WAIT_STATES = 0 gives rvalid the cycle after acceptance, the same as the single-cycle synchronous RAM. In general rvalid comes WAIT_STATES+1 cycles after acceptance.
- Back-to-back: gnt returns high in the same cycle rvalid is high, so a new request can be accepted in the rvalid cycle. Maximum throughput is 1/(WAIT_STATES+1) per port.
- WAIT counter: 4-bit, loads WAIT_STATES-1 at acceptance, decrements to 0, then moves to ACCESS.
- Writes: only byte lanes with d_be[k] = 1 are updated. d_be = 0 gives a write ack with no array change. On a write response d_rdata holds its previous value.
- rdata holds its value until the next read response.
- Error: addr[1:0] != 0 (misaligned) or word index >= DEPTH (only possible when DEPTH < 2^30).
  - err = 1 with the rvalid pulse.
  - No array write.
  - rdata = 0.
- Collision, both ports accessing the same word on the same access edge with the data port writing: i_rdata returns the old word by default.
- Reset (reset_n = 0 at an edge):
  - FSMs go to IDLE and any pending transaction is dropped with no array write.
  - gnt, rvalid, err = 0; rdata = 0.
  - Array contents are preserved.
  - Reset mid-WAIT produces no response after release.

Optional Feature:
- Macro: DP_MEMORY_WR_FWD_EN.
- Defined: on a collision, i_rdata returns the merged word, i.e. the old word with the d_be-selected lanes replaced by d_wdata (write-first).
- Undefined: read-first (old data), with no forwarding logic.

Decomposition:
- memory_pkg holds:
  - the FSM state enum (IDLE, WAIT, ACCESS);
  - word/byte address split constants;
  - a byte-merge function (old, new, be) -> word.
- One sub-module, memory_port_ctrl: per-port FSM, wait counter, request latching and error decode. Instantiated twice, once per port.
- The array and collision logic stay in dp_memory.

Test Plan:
- Reset then basic data path (WAIT_STATES=0): write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 -> d_rvalid one cycle after each accept; d_rdata = 0xDEADBEEF; d_err = 0.
- Byte strobes: word 0x20 holds 0x11223344; write 0xAABBCCDD with be=0b0101 -> readback 0x11BB33DD.
- Wait states (WAIT_STATES=3): i_req at 0x10 -> i_gnt low for 3 cycles after accept; i_rvalid exactly 4 cycles after accept; a back-to-back request is accepted in the rvalid cycle.
- Errors: d_addr=0x13 write -> d_err=1, d_rdata=0, memory unchanged. DEPTH=256, addr 0x400 -> err=1.
- Collision: same-cycle accept of i read and d write (0xCAFEF00D, be=0xF) to 0x40 holding 0x0 -> i_rdata=0x0 without the macro, 0xCAFEF00D with DP_MEMORY_WR_FWD_EN.
- Reset mid-operation (WAIT_STATES=3): write accepted, reset_n=0 for 1 cycle during WAIT -> no d_rvalid, target word unchanged, d_gnt high the cycle after reset release, prior contents intact.

Source files
------------

// File: rtl/memory_pkg.sv
// memory_pkg: shared FSM states, address split constants and byte-merge helper for dp_memory
package memory_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  localparam int WORD_LSB = 2;
  localparam int MAX_W = 256;
  localparam int MAX_BW = MAX_W / 8;
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w, input logic [MAX_W-1:0] new_w, input logic [MAX_BW-1:0] be);
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int k = 0; k < MAX_BW; k++) r[k*8+:8] = be[k] ? new_w[k*8+:8] : old_w[k*8+:8];
    return r;
  endfunction
endpackage

// File: rtl/memory_port_ctrl.sv
// memory_port_ctrl: per-port handshake FSM, wait counter, request latch and error decode
module memory_port_ctrl
  import memory_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req,
  input  logic                       we,
  input  logic [DATA_W/8-1:0]        be,
  input  logic [31:0]                addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic                       gnt,
  output logic                       access,
  output logic                       acc_we,
  output logic                       acc_err,
  output logic [$clog2(DEPTH)-1:0]   acc_idx,
  output logic [DATA_W/8-1:0]        acc_be,
  output logic [DATA_W-1:0]          acc_wdata
);
  localparam int AW = $clog2(DEPTH);
  state_t state, phase;
  logic [3:0] cnt;
  logic ok_q, we_q, live;
  logic [DATA_W/8-1:0] be_q;
  logic [31:0] addr_q, a;
  logic [DATA_W-1:0] wdata_q;
  assign gnt = state == IDLE && ok_q;
  assign live = state == IDLE;
  assign phase = (state == WAIT && cnt == 4'd0) || (live && gnt && req && WAIT_STATES == 0) ? ACCESS : state;
  assign access = reset_n && phase == ACCESS;
  assign a = live ? addr : addr_q;
  assign acc_we = live ? we : we_q;
  assign acc_be = live ? be : be_q;
  assign acc_wdata = live ? wdata : wdata_q;
  assign acc_idx = a[AW+WORD_LSB-1:WORD_LSB];
  assign acc_err = |a[WORD_LSB-1:0] || |(a >> (AW + WORD_LSB));
  // accept requests, count wait states and drop everything on reset
  always_ff @(posedge clock) begin
    ok_q <= reset_n;
    if (!reset_n) begin
      state <= IDLE;
      cnt <= 4'd0;
    end else if (live && gnt && req) begin
      addr_q <= addr;
      we_q <= we;
      be_q <= be;
      wdata_q <= wdata;
      state <= WAIT_STATES == 0 ? IDLE : WAIT;
      cnt <= 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
    end else if (state == WAIT) begin
      state <= cnt == 4'd0 ? IDLE : WAIT;
      cnt <= cnt == 4'd0 ? cnt : cnt - 4'd1;
    end
  end
endmodule

// File: rtl/dp_memory.sv
// dp_memory: dual-port word RAM (instruction read port, data read/write port); DP_MEMORY_WR_FWD_EN selects write-first collisions
module dp_memory
  import memory_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                i_req,
  output logic                i_gnt,
  input  logic [31:0]         i_addr,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  output logic                d_gnt,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [31:0]         d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = DATA_W / 8;
  logic [DATA_W-1:0] mem [DEPTH];
  logic i_acc, i_aerr, d_acc, d_awe, d_aerr, d_write;
  logic [AW-1:0] i_idx, d_idx;
  logic [BW-1:0] d_abe;
  logic [DATA_W-1:0] d_awdata, i_word, d_merged;
  memory_port_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(WAIT_STATES)) i_ctrl (
    .clock(clock), .reset_n(reset_n), .req(i_req), .we(1'b0), .be('0), .addr(i_addr), .wdata('0),
    .gnt(i_gnt), .access(i_acc), .acc_we(), .acc_err(i_aerr), .acc_idx(i_idx), .acc_be(), .acc_wdata()
  );
  memory_port_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(WAIT_STATES)) d_ctrl (
    .clock(clock), .reset_n(reset_n), .req(d_req), .we(d_we), .be(d_be), .addr(d_addr), .wdata(d_wdata),
    .gnt(d_gnt), .access(d_acc), .acc_we(d_awe), .acc_err(d_aerr), .acc_idx(d_idx), .acc_be(d_abe), .acc_wdata(d_awdata)
  );
  assign d_write = d_acc && d_awe && !d_aerr;
  assign d_merged = DATA_W'(byte_merge(MAX_W'(mem[d_idx]), MAX_W'(d_awdata), MAX_BW'(d_abe)));
`ifdef DP_MEMORY_WR_FWD_EN
  assign i_word = d_write && d_idx == i_idx ? d_merged : mem[i_idx];
`else
  assign i_word = mem[i_idx];
`endif
  // byte-lane write of the data port; array contents survive reset
  always_ff @(posedge clock) begin
    if (d_write) mem[d_idx] <= d_merged;
  end
  // registered responses; write acks keep d_rdata, errors force it to zero
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      i_rvalid <= 1'b0;
      i_err <= 1'b0;
      i_rdata <= '0;
      d_rvalid <= 1'b0;
      d_err <= 1'b0;
      d_rdata <= '0;
    end else begin
      i_rvalid <= i_acc;
      i_err <= i_acc && i_aerr;
      if (i_acc) i_rdata <= i_aerr ? '0 : i_word;
      d_rvalid <= d_acc;
      d_err <= d_acc && d_aerr;
      if (d_acc && (d_aerr || !d_awe)) d_rdata <= d_aerr ? '0 : mem[d_idx];
    end
  end
endmodule

// File: tb/tb_dp_memory.sv
// tb_dp_memory: two dp_memory instances (WS=0/DEPTH=1024 and WS=3/DEPTH=256) against a word-array reference
module tb_dp_memory;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n [2], i_req [2], i_gnt [2], i_rvalid [2], i_err [2];
  logic d_req [2], d_gnt [2], d_we [2], d_rvalid [2], d_err [2];
  logic [31:0] i_addr [2], i_rdata [2], d_addr [2], d_wdata [2], d_rdata [2];
  logic [3:0] d_be [2];
  for (genvar g = 0; g < 2; g++) begin : u
    dp_memory #(.DATA_W(32), .DEPTH(g == 0 ? 1024 : 256), .WAIT_STATES(g == 0 ? 0 : 3)) dut (
      .clock(clock), .reset_n(reset_n[g]),
      .i_req(i_req[g]), .i_gnt(i_gnt[g]), .i_addr(i_addr[g]), .i_rvalid(i_rvalid[g]), .i_rdata(i_rdata[g]), .i_err(i_err[g]),
      .d_req(d_req[g]), .d_gnt(d_gnt[g]), .d_we(d_we[g]), .d_be(d_be[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]), .d_err(d_err[g])
    );
  end
  logic [31:0] mdl [2][1024];
  logic [31:0] prev_i [2], prev_d [2];
  int total = 0, bad = 0;
  function automatic int dep(input int x);
    return x == 0 ? 1024 : 256;
  endfunction
  function automatic int ws(input int x);
    return x == 0 ? 0 : 3;
  endfunction
  function automatic logic [31:0] mrg(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (be[k]) r[k*8+:8] = new_w[k*8+:8];
    return r;
  endfunction
  function automatic bit bad_addr(input int x, input logic [31:0] a);
    return a[1:0] != 2'b00 || (a >> 2) >= 32'(dep(x));
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask
  task automatic xact(input int x, input bit p, input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat, output int wt, output bit early_gnt);
    wt = 0;
    lat = 0;
    early_gnt = 1'b0;
    if (p) begin
      d_req[x] = 1'b1; d_we[x] = we; d_be[x] = be; d_addr[x] = a; d_wdata[x] = wd;
    end else begin
      i_req[x] = 1'b1; i_addr[x] = a;
    end
    while (!(p ? d_gnt[x] : i_gnt[x]) && wt < 40) begin
      @(negedge clock);
      wt++;
    end
    @(posedge clock);
    #1;
    if (p) begin
      d_req[x] = 1'b0; d_we[x] = 1'($urandom); d_be[x] = 4'($urandom); d_addr[x] = $urandom; d_wdata[x] = $urandom;
    end else begin
      i_req[x] = 1'b0; i_addr[x] = $urandom;
    end
    do begin
      @(negedge clock);
      lat++;
      if (!(p ? d_rvalid[x] : i_rvalid[x]) && (p ? d_gnt[x] : i_gnt[x])) early_gnt = 1'b1;
    end while (!(p ? d_rvalid[x] : i_rvalid[x]) && lat < 40);
    rd = p ? d_rdata[x] : i_rdata[x];
    er = p ? d_err[x] : i_err[x];
  endtask
  task automatic run(input int x, input bit p, input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic [31:0] rd, exp;
    logic er;
    int lat, wt;
    bit eg, e;
    xact(x, p, we, be, a, wd, rd, er, lat, wt, eg);
    e = bad_addr(x, a);
    if (e) exp = 32'h0;
    else if (p && we) exp = prev_d[x];
    else exp = mdl[x][a >> 2];
    if (!e && p && we) mdl[x][a >> 2] = mrg(mdl[x][a >> 2], wd, be);
    if (p) prev_d[x] = exp; else prev_i[x] = exp;
    chk({tag, "_rdata"}, rd, exp);
    chk({tag, "_err"}, 32'(er), 32'(e));
    chk({tag, "_lat"}, 32'(lat), 32'(ws(x) + 1));
    chk({tag, "_wait"}, 32'(wt), 32'd0);
    chk({tag, "_busy"}, 32'(eg), 32'd0);
  endtask
  task automatic collide(input int x, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] ri, rdd, old_w, exp;
    logic ei, ed;
    int li, ld, wi, wd2;
    bit gi, gd;
    old_w = mdl[x][a >> 2];
    fork
      xact(x, 1'b0, 1'b0, 4'h0, a, 32'h0, ri, ei, li, wi, gi);
      xact(x, 1'b1, 1'b1, be, a, wd, rdd, ed, ld, wd2, gd);
    join
`ifdef DP_MEMORY_WR_FWD_EN
    exp = mrg(old_w, wd, be);
`else
    exp = old_w;
`endif
    mdl[x][a >> 2] = mrg(old_w, wd, be);
    prev_i[x] = exp;
    chk("coll_irdata", ri, exp);
    chk("coll_drdata", rdd, prev_d[x]);
    chk("coll_lat", 32'(li + ld), 32'(2 * (ws(x) + 1)));
  endtask
  initial begin
    int seen;
    for (int x = 0; x < 2; x++) begin
      reset_n[x] = 1'b0; i_req[x] = 1'b0; i_addr[x] = '0; d_req[x] = 1'b0; d_we[x] = 1'b0;
      d_be[x] = '0; d_addr[x] = '0; d_wdata[x] = '0; prev_i[x] = '0; prev_d[x] = '0;
    end
    repeat (3) @(negedge clock);
    for (int x = 0; x < 2; x++) begin
      chk("rst_ignt", 32'(i_gnt[x]), 32'd0);
      chk("rst_dgnt", 32'(d_gnt[x]), 32'd0);
      chk("rst_rvalid", 32'({i_rvalid[x], d_rvalid[x], i_err[x], d_err[x]}), 32'd0);
      chk("rst_irdata", i_rdata[x], 32'h0);
      chk("rst_drdata", d_rdata[x], 32'h0);
      reset_n[x] = 1'b1;
    end
    @(negedge clock);
    for (int x = 0; x < 2; x++) chk("gnt_after_rst", 32'({i_gnt[x], d_gnt[x]}), 32'd3);
    for (int x = 0; x < 2; x++) for (int w = 0; w < 64; w++) run(x, 1'b1, 1'b1, 4'hF, 32'(w * 4), 32'h0, "init");
    run(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "basic_wr");
    run(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, "basic_rd");
    chk("basic_val", d_rdata[0], 32'hDEADBEEF);
    run(0, 1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344, "be_init");
    run(0, 1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, "be_wr");
    run(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, "be_rd");
    chk("be_val", d_rdata[0], 32'h11BB33DD);
    run(0, 1'b1, 1'b1, 4'hF, 32'h13, 32'h12345678, "mis_wr");
    run(0, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0, "mis_keep");
    chk("mis_keep_val", i_rdata[0], 32'hDEADBEEF);
    run(1, 1'b0, 1'b0, 4'h0, 32'h400, 32'h0, "range_rd");
    run(1, 1'b1, 1'b1, 4'hF, 32'h400, 32'hFFFFFFFF, "range_wr");
    run(1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, "range_keep");
    run(0, 1'b1, 1'b1, 4'hF, 32'h1000, 32'h1, "range0_wr");
    collide(0, 32'h40, 32'hCAFEF00D, 4'hF);
`ifdef DP_MEMORY_WR_FWD_EN
    chk("coll_const", i_rdata[0], 32'hCAFEF00D);
`else
    chk("coll_const", i_rdata[0], 32'h0);
`endif
    run(1, 1'b1, 1'b1, 4'hF, 32'h10, 32'h0BADF00D, "ws_wr");
    run(1, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0, "ws_rd");
    chk("b2b_gnt", 32'({i_gnt[1], i_rvalid[1]}), 32'd3);
    run(1, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0, "b2b_rd");
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_be[1] = 4'hF; d_addr[1] = 32'h30; d_wdata[1] = 32'h55AA55AA;
    @(posedge clock);
    #1 d_req[1] = 1'b0;
    @(negedge clock);
    reset_n[1] = 1'b0;
    seen = 0;
    @(negedge clock);
    chk("midrst_gnt_low", 32'(d_gnt[1]), 32'd0);
    reset_n[1] = 1'b1;
    @(negedge clock);
    chk("midrst_gnt_high", 32'(d_gnt[1]), 32'd1);
    for (int c = 0; c < 8; c++) begin
      if (d_rvalid[1]) seen++;
      @(negedge clock);
    end
    chk("midrst_no_rvalid", 32'(seen), 32'd0);
    prev_i[1] = '0;
    prev_d[1] = '0;
    run(1, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0, "midrst_word");
    run(1, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0, "midrst_prior");
    chk("midrst_prior_val", i_rdata[1], 32'h0BADF00D);
    for (int n = 0; n < 300; n++) begin
      int x, sel;
      logic [31:0] a;
      x = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 63)) << 2;
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      if (sel == 1) a = a + 32'(dep(x) * 4);
      if (sel == 9) collide(x, a, $urandom, 4'($urandom));
      else run(x, 1'($urandom), 1'($urandom), 4'($urandom), a, $urandom, "rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
